// File: rtl/radiant_trig_evgen.sv
// Trigger event generator: merges enabled hardware/software triggers into numbered event strobes.
// Latency: event_o asserts one cycle after the sampled trigger flag.
// Backpressure: event_busy_i stretches the deadtime; hits in deadtime are dropped and counted.
//
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   trig_flag_i, trig_en_i    NUM_TRIG one-cycle hardware trigger flags and their enables
//   soft_trig_i, soft_en_i    software trigger flag and enable
//   holdoff_i                 deadtime in cycles, sampled when the event is issued
//   event_busy_i              downstream cannot take a new event (holds the deadtime)
//   cnt_clr_i                 synchronous clear of the sequence and dropped counters
//   event_o, event_info_o     one-cycle event strobe; {seq[23:0], hit[7:0]} held until next event
//   dropped_o                 saturating count of rejected enabled triggers
//   state_o                   current FSM state (debug)
module radiant_trig_evgen #(
    parameter int NUM_TRIG      = 2,
    parameter int HOLDOFF_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NUM_TRIG-1:0]      trig_flag_i,
    input  logic [NUM_TRIG-1:0]      trig_en_i,
    input  logic                     soft_trig_i,
    input  logic                     soft_en_i,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff_i,
    input  logic                     event_busy_i,
    input  logic                     cnt_clr_i,
    output logic                     event_o,
    output logic [31:0]              event_info_o,
    output logic [15:0]              dropped_o,
    output logic [1:0]               state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam logic [HOLDOFF_WIDTH-1:0] CNT_ONE = 1;

    state_t                   state_q, state_d;
    logic [HOLDOFF_WIDTH-1:0] cnt_q, cnt_d;
    logic [23:0]              seq_q, seq_d;
    logic [31:0]              info_q, info_d;
    logic [15:0]              drop_q, drop_d;
    logic [7:0]               hit;
    logic                     hit_any;

    // Hardware sources occupy the low bits, software trigger is always bit 7;
    // unused bits in between stay zero.
    always_comb begin
        hit                 = 8'h00;
        hit[NUM_TRIG-1:0]   = trig_flag_i & trig_en_i;
        hit[7]              = soft_trig_i & soft_en_i;
    end

    assign hit_any = |hit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        info_d  = info_q;
        // A clear lands before any increment so a coincident capture numbers from zero.
        seq_d   = cnt_clr_i ? 24'h000000 : seq_q;
        drop_d  = cnt_clr_i ? 16'h0000 : drop_q;

        case (state_q)
            ST_IDLE: begin
                if (hit_any) begin
                    info_d  = {seq_d, hit};
                    seq_d   = seq_d + 24'd1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = holdoff_i;
                state_d = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (!event_busy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // One drop per cycle no matter how many sources fired; sticks at all-ones.
        if ((state_q == ST_ISSUE || state_q == ST_HOLDOFF) && hit_any && !cnt_clr_i
                && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            seq_q   <= '0;
            info_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            info_q  <= info_d;
            drop_q  <= drop_d;
        end
    end

    assign event_o      = (state_q == ST_ISSUE);
    assign event_info_o = info_q;
    assign dropped_o    = drop_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_radiant_trig_evgen.sv
module tb_radiant_trig_evgen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  tf, te;
    logic        st, se;
    logic [15:0] ho;
    logic        busy, clr;
    logic        evt;
    logic [31:0] info;
    logic [15:0] drop;
    logic [1:0]  state;

    always #5 clk = ~clk;

    radiant_trig_evgen #(.NUM_TRIG(2), .HOLDOFF_WIDTH(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .trig_flag_i(tf), .trig_en_i(te),
        .soft_trig_i(st), .soft_en_i(se),
        .holdoff_i(ho), .event_busy_i(busy), .cnt_clr_i(clr),
        .event_o(evt), .event_info_o(info), .dropped_o(drop), .state_o(state)
    );

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b1;

    // Timeline reference: after an accepted trigger the block is blind until the
    // deadtime (sampled on the event cycle) has elapsed and busy is low.
    bit          m_event   = 1'b0;
    logic [31:0] m_info    = '0;
    int          m_drop    = 0;
    logic [23:0] m_seq     = '0;
    bit          m_blocked = 1'b0;
    longint      m_rel     = 0;
    longint      cyc       = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic [7:0]  h;
        logic [23:0] s;
        bit          new_ev;
        new_ev = 1'b0;
        if (!rst_n) begin
            m_event = 1'b0; m_info = '0; m_drop = 0; m_seq = '0; m_blocked = 1'b0; m_rel = 0;
        end else begin
            h = {st & se, 5'b00000, tf & te};
            if (!m_blocked) begin
                s = clr ? 24'h0 : m_seq;
                if (clr) m_drop = 0;
                if (h != 8'h00) begin
                    m_info    = {s, h};
                    s         = s + 24'd1;
                    m_blocked = 1'b1;
                    new_ev    = 1'b1;
                end
                m_seq = s;
            end else begin
                if (clr) begin
                    m_seq  = '0;
                    m_drop = 0;
                end else if (h != 8'h00 && m_drop < 65535) begin
                    m_drop++;
                end
                if (m_event) m_rel = cyc + 1 + longint'(ho);
                else if (cyc >= m_rel && !busy) m_blocked = 1'b0;
            end
            m_event = new_ev;
        end
        cyc++;
    endtask

    // One clock: model consumes this cycle's inputs at the edge, outputs compared 1ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (mon_en) begin
            tests++;
            if (evt !== m_event || info !== m_info || drop !== m_drop[15:0]) begin
                fails++;
                $display("FAIL model cyc=%0d: evt/info/drop got %b/%h/%h expected %b/%h/%h",
                         cyc, evt, info, drop, m_event, m_info, m_drop[15:0]);
            end
        end
    endtask

    task automatic idle(input int n);
        tf = '0; st = 1'b0; clr = 1'b0; busy = 1'b0;
        repeat (n) tick();
    endtask

    typedef struct {
        logic [1:0] tf;
        logic [1:0] te;
        logic       st;
        logic       se;
        logic       ev;
        logic [7:0] lo;
    } vec_t;

    vec_t        vt[8];
    logic [23:0] exp_seq;
    logic [31:0] exp_info;
    logic [63:0] pat, exp_pat;

    initial begin
        rst_n = 1'b0; tf = '0; te = '0; st = 1'b0; se = 1'b0;
        ho = '0; busy = 1'b0; clr = 1'b0;
        #1;
        check("reset_event", {63'd0, evt}, 64'd0);
        check("reset_info", {32'd0, info}, 64'd0);
        check("reset_dropped", {48'd0, drop}, 64'd0);
        check("reset_state", {62'd0, state}, 64'd0);
        tick(); tick();
        rst_n = 1'b1;

        // Single-cycle vectors from IDLE; the first one lands on the first edge after reset.
        vt[0] = '{2'b01, 2'b11, 1'b0, 1'b0, 1'b1, 8'h01};
        vt[1] = '{2'b10, 2'b11, 1'b0, 1'b0, 1'b1, 8'h02};
        vt[2] = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 8'h83};
        vt[3] = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[4] = '{2'b11, 2'b10, 1'b0, 1'b1, 1'b1, 8'h02};
        vt[5] = '{2'b00, 2'b11, 1'b1, 1'b1, 1'b1, 8'h80};
        vt[6] = '{2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[7] = '{2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00};
        exp_seq  = '0;
        exp_info = '0;
        for (int i = 0; i < 8; i++) begin
            tf = vt[i].tf; te = vt[i].te; st = vt[i].st; se = vt[i].se;
            tick();
            if (vt[i].ev) begin
                exp_info = {exp_seq, vt[i].lo};
                exp_seq  = exp_seq + 24'd1;
            end
            check($sformatf("vec%0d_event", i), {63'd0, evt}, {63'd0, vt[i].ev});
            check($sformatf("vec%0d_info", i), {32'd0, info}, {32'd0, exp_info});
            check($sformatf("vec%0d_dropped", i), {48'd0, drop}, 64'd0);
            idle(3);
        end

        // Burst: 20 consecutive hits with deadtime 4 -> events every 7 cycles.
        te = 2'b11; se = 1'b1; clr = 1'b1; tick(); clr = 1'b0;
        ho = 16'd4; tf = 2'b01;
        pat = '0; exp_pat = '0;
        for (int k = 1; k <= 22; k++) begin
            tick();
            pat[k]     = evt;
            exp_pat[k] = (k == 1 || k == 8 || k == 15);
            tf         = (k < 20) ? 2'b01 : 2'b00;
        end
        check("burst_events", pat, exp_pat);
        check("burst_dropped", {48'd0, drop}, 64'd17);
        idle(4);

        // Busy hold with zero deadtime: next event two cycles after busy drops.
        ho = '0; clr = 1'b1; tick(); clr = 1'b0;
        tf = 2'b01;
        pat = '0; exp_pat = '0;
        for (int k = 1; k <= 56; k++) begin
            tick();
            pat[k]     = evt;
            exp_pat[k] = (k == 1 || k == 53);
            busy       = (k <= 50);
            tf         = (k <= 52) ? 2'b01 : 2'b00;
        end
        check("busy_events", pat, exp_pat);
        check("busy_dropped", {48'd0, drop}, 64'd51);
        idle(4);

        // Saturation of the dropped counter while busy holds the deadtime.
        clr = 1'b1; tick(); clr = 1'b0;
        busy = 1'b1; tf = 2'b10;
        repeat (65540) tick();
        check("drop_saturate", {48'd0, drop}, 64'h0000_0000_0000_FFFF);
        check("drop_sat_state", {62'd0, state}, 64'd2);
        idle(4);
        clr = 1'b1; tick(); clr = 1'b0;
        check("drop_cleared", {48'd0, drop}, 64'd0);

        // Sequence wrap and clear-on-capture, checked directly.
        mon_en = 1'b0;
        idle(2);
        force dut.seq_q = 24'hFFFFFF;
        tick();
        release dut.seq_q;
        tf = 2'b01; tick(); tf = 2'b00;
        check("wrap_last", {32'd0, info}, 64'h0000_0000_FFFF_FF01);
        idle(3);
        tf = 2'b10; tick(); tf = 2'b00;
        check("wrap_zero", {32'd0, info}, 64'h0000_0000_0000_0002);
        idle(3);
        te = 2'b11; tf = 2'b11; tick(); tf = 2'b00;
        check("pre_clr_seq1", {32'd0, info}, 64'h0000_0000_0000_0103);
        idle(3);
        tf = 2'b01; clr = 1'b1; tick(); tf = 2'b00; clr = 1'b0;
        check("clr_capture_seq0", {32'd0, info}, 64'h0000_0000_0000_0001);
        idle(3);
        tf = 2'b01; tick(); tf = 2'b00;
        check("clr_capture_seq1", {32'd0, info}, 64'h0000_0000_0000_0101);
        idle(3);

        // Reset in the middle of a 100-cycle deadtime.
        ho = 16'd100; tf = 2'b01; tick();
        repeat (51) tick();
        check("mid_holdoff_state", {62'd0, state}, 64'd2);
        check("mid_holdoff_dropped", {48'd0, drop}, 64'd51);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_event", {63'd0, evt}, 64'd0);
        check("async_rst_info", {32'd0, info}, 64'd0);
        check("async_rst_dropped", {48'd0, drop}, 64'd0);
        check("async_rst_state", {62'd0, state}, 64'd0);
        tf = 2'b00;
        tick(); tick();
        mon_en = 1'b1;
        rst_n = 1'b1; tf = 2'b01; tick(); tf = 2'b00;
        check("post_rst_event", {63'd0, evt}, 64'd1);
        check("post_rst_info", {32'd0, info}, 64'h0000_0000_0000_0001);
        idle(110);

        // Randomized traffic against the reference timeline.
        for (int n = 0; n < 3000; n++) begin
            tf   = ($urandom_range(0, 2) == 0) ? 2'(($urandom_range(1, 3))) : 2'b00;
            te   = 2'($urandom_range(0, 3));
            st   = ($urandom_range(0, 5) == 0);
            se   = ($urandom_range(0, 1) == 0);
            ho   = 16'($urandom_range(0, 6));
            busy = ($urandom_range(0, 7) == 0);
            clr  = ($urandom_range(0, 63) == 0);
            tick();
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
